mure_block_retirement: RTL and testbench
========================================

Name: mure_block_retirement

Overview:
- Consumes uop entries popped from the trace uop FIFO, one per handshake. Groups consecutively retired instructions into E-Trace instruction blocks: start address, retired halfword count, closing itype.
- Each completed block goes through a registered valid/ready output to the packet-emitter stage downstream.
- Uses the package IDLE/COUNT state encoding.

Parameters:
- XLEN, 32 (64 with TRDB_ARCH64): address/tval width.
- IRETIRE_LEN, 32: width of the halfword counter.
- IRETIRE_MAX, 4095: a block is force-closed once its count reaches this value.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- uop_valid_i  in  1  uop entry valid.
- uop_ready_o  out  1  uop entry accepted when valid&ready.
- uop_pc_i  in  XLEN  instruction address.
- uop_itype_i  in  ITYPE_LEN  itype_e code.
- uop_compressed_i  in  1  1 = 16-bit instruction.
- uop_exception_i  in  1  exception taken at this pc.
- uop_interrupt_i  in  1  interrupt taken at this pc.
- uop_cause_i  in  CAUSE_LEN  trap cause.
- uop_tval_i  in  XLEN  trap value.
- uop_priv_i  in  PRIV_LEN  privilege of instruction.
- blk_valid_o  out  1  block record valid.
- blk_ready_i  in  1  downstream accepts record.
- blk_iaddr_o  out  XLEN  address of first instruction in block.
- blk_iretire_o  out  IRETIRE_LEN  halfwords retired in block.
- blk_itype_o  out  ITYPE_LEN  closing itype.
- blk_cause_o  out  CAUSE_LEN  cause (EXC/INT blocks, else 0).
- blk_tval_o  out  XLEN  tval (EXC blocks, else 0).
- blk_priv_o  out  PRIV_LEN  priv of closing uop.

Behaviour:
- Reset: state=IDLE, count=0, start address=0. All blk_* outputs are 0, including blk_valid_o. A partial block in progress is discarded with no output. Reset overrides everything, including a handshake in the same cycle.
- Handshake: uop_ready_o = !blk_valid_o | blk_ready_i, combinational. A pending unaccepted record stalls input.
- Output record fields are held stable while blk_valid_o=1 and blk_ready_i=0.
- Instruction size: 1 halfword if compressed, else 2.
- Trap uop: uop_exception_i|uop_interrupt_i. Exception has priority if both are set.
  - The trapping instruction is not counted.
  - Closes the current block with itype EXC (exception) or INT (interrupt).
  - blk_cause_o = uop_cause_i. blk_tval_o = uop_tval_i for EXC, 0 for INT.
- Closing itype: NTB, TB, UIJ, ERET. The instruction is counted, then the block closes with that itype.
- STD and RES are ordinary instructions.
- State IDLE, accepted uop:
  - Trap: emit block with iaddr=pc, iretire=0, itype EXC/INT. Stay in IDLE.
  - Closing itype: emit iaddr=pc, iretire=size, itype. Stay in IDLE.
  - Else: latch start=pc, count=size. Go to COUNT. If size>=IRETIRE_MAX, emit immediately with STD and stay in IDLE.
- State COUNT, accepted uop:
  - Trap: emit start/count with EXC/INT. Go to IDLE.
  - Closing itype: emit start, count+size, itype. Go to IDLE.
  - Else: count+=size. If the new count>=IRETIRE_MAX, emit with itype STD and go to IDLE. Otherwise stay in COUNT.
- Latency: the record is registered. blk_valid_o rises the cycle after the closing uop is accepted.
- Back-to-back: a new block may start in the same cycle the previous record is accepted downstream.
- Counter arithmetic is IRETIRE_LEN wide. IRETIRE_MAX < 2^IRETIRE_LEN, so the counter never wraps.
- No uop valid: state and count hold. There is no timeout flush.

Optional Feature:
- Macro MURE_ILASTSIZE_EN.
- Defined:
  - Adds output blk_ilastsize_o (1 bit): 0 = last counted instruction was 16-bit, 1 = 32-bit.
  - It is 0 for iretire=0 blocks and 0 on reset.
  - It is held with the record under backpressure.
- Not defined: the port does not exist and there is no related logic.

Test Plan:
- Basic block: blk_ready_i=1; uops 0x80000000 (32-bit STD), 0x80000004 (compressed STD), 0x80000006 (32-bit TB) on consecutive cycles -> one cycle after the third uop: blk_valid_o=1, iaddr 0x80000000, iretire 5, itype TB. No record earlier.
- Backpressure: record pending, blk_ready_i=0 for 3 cycles, uop_valid_i=1 -> uop_ready_o=0, record fields constant. blk_ready_i=1 -> that cycle's uop is accepted.
- Exception: 32-bit STD at 0xF8, 0xFC, then exception at 0x100 with cause 2, tval 0xDEAD -> iaddr 0xF8, iretire 4, itype EXC, cause 2, tval 0xDEAD. Interrupt from IDLE at 0x200 with cause 7 -> iaddr 0x200, iretire 0, itype INT, tval 0.
- Saturation: IRETIRE_MAX=8, five 32-bit STD starting at 0x1000 -> record iaddr 0x1000, iretire 8, itype STD after the fourth. The fifth opens a new block at 0x1010.
- Reset mid-block: two STD accepted, rst_i high for 1 cycle, then a TB at 0x40 (32-bit) -> outputs 0 during reset. Record iaddr 0x40, iretire 2; the earlier instructions are lost.
- With MURE_ILASTSIZE_EN: block ending in compressed NTB -> ilastsize 0. Block ending in 32-bit UIJ -> 1.

Source files
------------

// File: rtl/mure_block_retirement.sv
// Groups retired uops into E-Trace instruction blocks (start address, halfword count, closing itype).
// Optional MURE_ILASTSIZE_EN adds blk_ilastsize_o (size of the last counted instruction).
module mure_block_retirement #(
`ifdef TRDB_ARCH64
  parameter int XLEN        = 64,
`else
  parameter int XLEN        = 32,
`endif
  parameter int IRETIRE_LEN = 32,
  parameter int IRETIRE_MAX = 4095,
  parameter int ITYPE_LEN   = 3,
  parameter int CAUSE_LEN   = 5,
  parameter int PRIV_LEN    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   uop_valid_i,
  output logic                   uop_ready_o,
  input  logic [XLEN-1:0]        uop_pc_i,
  input  logic [ITYPE_LEN-1:0]   uop_itype_i,
  input  logic                   uop_compressed_i,
  input  logic                   uop_exception_i,
  input  logic                   uop_interrupt_i,
  input  logic [CAUSE_LEN-1:0]   uop_cause_i,
  input  logic [XLEN-1:0]        uop_tval_i,
  input  logic [PRIV_LEN-1:0]    uop_priv_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [XLEN-1:0]        blk_iaddr_o,
  output logic [IRETIRE_LEN-1:0] blk_iretire_o,
  output logic [ITYPE_LEN-1:0]   blk_itype_o,
  output logic [CAUSE_LEN-1:0]   blk_cause_o,
  output logic [XLEN-1:0]        blk_tval_o,
`ifdef MURE_ILASTSIZE_EN
  output logic                   blk_ilastsize_o,
`endif
  output logic [PRIV_LEN-1:0]    blk_priv_o
);

  localparam logic [ITYPE_LEN-1:0] ITYPE_STD  = ITYPE_LEN'(0);
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = ITYPE_LEN'(2);
  localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = ITYPE_LEN'(3);
  localparam logic [ITYPE_LEN-1:0] ITYPE_NTB  = ITYPE_LEN'(4);
  localparam logic [ITYPE_LEN-1:0] ITYPE_TB   = ITYPE_LEN'(5);
  localparam logic [ITYPE_LEN-1:0] ITYPE_UIJ  = ITYPE_LEN'(6);
  localparam logic [IRETIRE_LEN-1:0] CNT_MAX  = IRETIRE_LEN'(IRETIRE_MAX);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                 state_reg, state_next;
  logic [IRETIRE_LEN-1:0] count_reg, count_next;
  logic [XLEN-1:0]        start_reg, start_next;

  logic                   fire, trap, closing, in_count;
  logic [IRETIRE_LEN-1:0] size, base, new_count;
  logic [XLEN-1:0]        first_pc;

  logic                   emit;
  logic [IRETIRE_LEN-1:0] emit_iretire;
  logic [ITYPE_LEN-1:0]   emit_itype;
  logic [CAUSE_LEN-1:0]   emit_cause;
  logic [XLEN-1:0]        emit_tval;

`ifdef MURE_ILASTSIZE_EN
  logic last_size_reg, last_size_next, emit_last;
`endif

  // A pending record blocks input; it frees up the cycle downstream takes it.
  assign uop_ready_o = !blk_valid_o | blk_ready_i;

  always_comb begin
    fire      = uop_valid_i & uop_ready_o;
    trap      = uop_exception_i | uop_interrupt_i;
    closing   = (uop_itype_i == ITYPE_NTB) | (uop_itype_i == ITYPE_TB) |
                (uop_itype_i == ITYPE_UIJ) | (uop_itype_i == ITYPE_ERET);
    in_count  = (state_reg == COUNT);
    size      = uop_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    base      = in_count ? count_reg : '0;
    first_pc  = in_count ? start_reg : uop_pc_i;
    new_count = base + size;
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    start_next   = start_reg;
    emit         = 1'b0;
    emit_iretire = new_count;
    emit_itype   = ITYPE_STD;
    emit_cause   = '0;
    emit_tval    = '0;
`ifdef MURE_ILASTSIZE_EN
    last_size_next = last_size_reg;
    emit_last      = !uop_compressed_i;
`endif
    if (fire) begin
      if (trap) begin
        // The trapping instruction itself never retires, so it is not counted.
        emit         = 1'b1;
        emit_iretire = base;
        emit_itype   = uop_exception_i ? ITYPE_EXC : ITYPE_INT;
        emit_cause   = uop_cause_i;
        emit_tval    = uop_exception_i ? uop_tval_i : '0;
        state_next   = IDLE;
        count_next   = '0;
`ifdef MURE_ILASTSIZE_EN
        emit_last    = in_count ? last_size_reg : 1'b0;
`endif
      end else if (closing) begin
        emit       = 1'b1;
        emit_itype = uop_itype_i;
        state_next = IDLE;
        count_next = '0;
      end else if (new_count >= CNT_MAX) begin
        emit       = 1'b1;
        state_next = IDLE;
        count_next = '0;
      end else begin
        state_next = COUNT;
        count_next = new_count;
        start_next = first_pc;
`ifdef MURE_ILASTSIZE_EN
        last_size_next = !uop_compressed_i;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      count_reg <= '0;
      start_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      start_reg <= start_next;
    end
  end

  // Record register: only reloaded on a handshake, so fields hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_valid_o   <= 1'b0;
      blk_iaddr_o   <= '0;
      blk_iretire_o <= '0;
      blk_itype_o   <= '0;
      blk_cause_o   <= '0;
      blk_tval_o    <= '0;
      blk_priv_o    <= '0;
    end else if (emit) begin
      blk_valid_o   <= 1'b1;
      blk_iaddr_o   <= first_pc;
      blk_iretire_o <= emit_iretire;
      blk_itype_o   <= emit_itype;
      blk_cause_o   <= emit_cause;
      blk_tval_o    <= emit_tval;
      blk_priv_o    <= uop_priv_i;
    end else if (blk_ready_i) begin
      blk_valid_o   <= 1'b0;
    end
  end

`ifdef MURE_ILASTSIZE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_size_reg   <= 1'b0;
      blk_ilastsize_o <= 1'b0;
    end else begin
      last_size_reg <= last_size_next;
      if (emit) blk_ilastsize_o <= emit_last;
    end
  end
`endif

endmodule

// File: tb/tb_mure_block_retirement.sv
// Scoreboard bench for mure_block_retirement: a reference model queues expected block
// records as uops are accepted; a monitor pops and compares on every output handshake.
module tb_mure_block_retirement;

`ifdef TRDB_ARCH64
  localparam int XLEN = 64;
`else
  localparam int XLEN = 32;
`endif
  localparam int IRETIRE_LEN = 32;
  localparam int IRETIRE_MAX = 8;

  localparam logic [2:0] STD = 3'd0, EXC = 3'd1, INT = 3'd2, ERET = 3'd3,
                         NTB = 3'd4, TB  = 3'd5, UIJ = 3'd6, RES  = 3'd7;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   uop_valid_i, uop_ready_o;
  logic [XLEN-1:0]        uop_pc_i;
  logic [2:0]             uop_itype_i;
  logic                   uop_compressed_i, uop_exception_i, uop_interrupt_i;
  logic [4:0]             uop_cause_i;
  logic [XLEN-1:0]        uop_tval_i;
  logic [1:0]             uop_priv_i;
  logic                   blk_valid_o, blk_ready_i;
  logic [XLEN-1:0]        blk_iaddr_o;
  logic [IRETIRE_LEN-1:0] blk_iretire_o;
  logic [2:0]             blk_itype_o;
  logic [4:0]             blk_cause_o;
  logic [XLEN-1:0]        blk_tval_o;
  logic [1:0]             blk_priv_o;
`ifdef MURE_ILASTSIZE_EN
  logic                   blk_ilastsize_o;
`endif

  always #5 clk_i = ~clk_i;

  mure_block_retirement #(
    .XLEN(XLEN), .IRETIRE_LEN(IRETIRE_LEN), .IRETIRE_MAX(IRETIRE_MAX),
    .ITYPE_LEN(3), .CAUSE_LEN(5), .PRIV_LEN(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .uop_valid_i(uop_valid_i), .uop_ready_o(uop_ready_o),
    .uop_pc_i(uop_pc_i), .uop_itype_i(uop_itype_i),
    .uop_compressed_i(uop_compressed_i), .uop_exception_i(uop_exception_i),
    .uop_interrupt_i(uop_interrupt_i), .uop_cause_i(uop_cause_i),
    .uop_tval_i(uop_tval_i), .uop_priv_i(uop_priv_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
    .blk_iaddr_o(blk_iaddr_o), .blk_iretire_o(blk_iretire_o),
    .blk_itype_o(blk_itype_o), .blk_cause_o(blk_cause_o),
    .blk_tval_o(blk_tval_o),
`ifdef MURE_ILASTSIZE_EN
    .blk_ilastsize_o(blk_ilastsize_o),
`endif
    .blk_priv_o(blk_priv_o)
  );

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic [2:0]             itype;
    logic [4:0]             cause;
    logic [XLEN-1:0]        tval;
    logic [1:0]             priv;
    logic                   ilast;
  } rec_t;

  rec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic                   m_active;
  logic [IRETIRE_LEN-1:0] m_count;
  logic [XLEN-1:0]        m_start;
  logic                   m_last;

  function automatic rec_t dut_rec();
    rec_t r;
    r.iaddr   = blk_iaddr_o;
    r.iretire = blk_iretire_o;
    r.itype   = blk_itype_o;
    r.cause   = blk_cause_o;
    r.tval    = blk_tval_o;
    r.priv    = blk_priv_o;
`ifdef MURE_ILASTSIZE_EN
    r.ilast   = blk_ilastsize_o;
`else
    r.ilast   = 1'b0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_count  = '0;
    m_start  = '0;
    m_last   = 1'b0;
  endtask

  task automatic model_accept(input logic [XLEN-1:0] pc, input logic [2:0] itype,
                              input logic comp, input logic exc, input logic intr,
                              input logic [4:0] cause, input logic [XLEN-1:0] tval,
                              input logic [1:0] priv);
    rec_t r;
    logic [IRETIRE_LEN-1:0] sz, nc;
    sz = comp ? 1 : 2;
    nc = (m_active ? m_count : 0) + sz;
    r.iaddr = m_active ? m_start : pc;
    r.priv  = priv;
    r.cause = '0;
    r.tval  = '0;
    r.ilast = 1'b0;
    if (exc || intr) begin
      r.iretire = m_active ? m_count : 0;
      r.itype   = exc ? EXC : INT;
      r.cause   = cause;
      r.tval    = exc ? tval : '0;
`ifdef MURE_ILASTSIZE_EN
      r.ilast   = m_active ? m_last : 1'b0;
`endif
      exp_q.push_back(r);
      m_active = 1'b0;
    end else if (itype == NTB || itype == TB || itype == UIJ || itype == ERET ||
                 nc >= IRETIRE_MAX) begin
      r.iretire = nc;
      r.itype   = (nc >= IRETIRE_MAX && !(itype == NTB || itype == TB ||
                   itype == UIJ || itype == ERET)) ? STD : itype;
`ifdef MURE_ILASTSIZE_EN
      r.ilast   = !comp;
`endif
      exp_q.push_back(r);
      m_active = 1'b0;
    end else begin
      if (!m_active) m_start = pc;
      m_active = 1'b1;
      m_count  = nc;
      m_last   = !comp;
    end
  endtask

  // Monitor: every record taken downstream must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && blk_valid_o && blk_ready_i) begin
      rec_t got, e;
      got = dut_rec();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_record: got iaddr=%h iretire=%0d itype=%0d, required none",
                 got.iaddr, got.iretire, got.itype);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL record: got iaddr=%h iretire=%0d itype=%0d cause=%0d tval=%h priv=%0d ilast=%0d, required iaddr=%h iretire=%0d itype=%0d cause=%0d tval=%h priv=%0d ilast=%0d",
                   got.iaddr, got.iretire, got.itype, got.cause, got.tval, got.priv, got.ilast,
                   e.iaddr, e.iretire, e.itype, e.cause, e.tval, e.priv, e.ilast);
        end else begin
          $display("record ok: iaddr=%h iretire=%0d itype=%0d", got.iaddr, got.iretire, got.itype);
        end
      end
    end
  end

  // Drives one uop and returns #1 after the edge that accepted it.
  task automatic send(input logic [XLEN-1:0] pc, input logic [2:0] itype, input logic comp,
                      input logic exc = 1'b0, input logic intr = 1'b0,
                      input logic [4:0] cause = '0, input logic [XLEN-1:0] tval = '0,
                      input logic [1:0] priv = 2'd3);
    int n;
    uop_valid_i = 1'b1; uop_pc_i = pc; uop_itype_i = itype; uop_compressed_i = comp;
    uop_exception_i = exc; uop_interrupt_i = intr; uop_cause_i = cause;
    uop_tval_i = tval; uop_priv_i = priv;
    n = 0;
    @(negedge clk_i);
    while (!uop_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!uop_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: uop_ready_o=%0d, required 1 within 20 cycles", uop_ready_o);
    end else begin
      @(posedge clk_i);
      model_accept(pc, itype, comp, exc, intr, cause, tval, priv);
    end
    #1;
    uop_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk_i);
      n++;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if ({blk_valid_o, blk_iaddr_o, blk_iretire_o, blk_itype_o, blk_cause_o, blk_tval_o,
         blk_priv_o} !== '0 || uop_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%0d iaddr=%h iretire=%0d ready=%0d, required all 0 and ready=1",
               blk_valid_o, blk_iaddr_o, blk_iretire_o, uop_ready_o);
    end
`ifdef MURE_ILASTSIZE_EN
    vectors++;
    if (blk_ilastsize_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ilastsize: got %0d, required 0", blk_ilastsize_o);
    end
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_block();
    send(32'h8000_0000, STD, 1'b0);
    send(32'h8000_0004, STD, 1'b1);
    send(32'h8000_0006, TB,  1'b0);
    vectors++;
    if (blk_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: blk_valid_o=%0d one cycle after closing uop, required 1", blk_valid_o);
    end
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    rec_t snap;
    blk_ready_i = 1'b0;
    send(32'h300, NTB, 1'b1, 1'b0, 1'b0, '0, '0, 2'd1);
    @(negedge clk_i);
    snap = dut_rec();
    uop_valid_i = 1'b1; uop_pc_i = 32'h400; uop_itype_i = UIJ; uop_compressed_i = 1'b0;
    uop_exception_i = 1'b0; uop_interrupt_i = 1'b0; uop_cause_i = '0; uop_tval_i = '0;
    uop_priv_i = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      vectors++;
      if (uop_ready_o !== 1'b0 || blk_valid_o !== 1'b1 || dut_rec() !== snap) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: ready=%0d valid=%0d iaddr=%h, required ready=0 valid=1 iaddr=%h held",
                 i, uop_ready_o, blk_valid_o, blk_iaddr_o, snap.iaddr);
      end
    end
    @(posedge clk_i); #1;
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (uop_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: uop_ready_o=%0d, required 1", uop_ready_o);
    end
    @(posedge clk_i);
    model_accept(32'h400, UIJ, 1'b0, 1'b0, 1'b0, '0, '0, 2'd0);
    #1;
    uop_valid_i = 1'b0;
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL backpressure_drain: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_traps();
    send(32'hF8,  STD, 1'b0);
    send(32'hFC,  STD, 1'b0);
    send(32'h100, STD, 1'b0, 1'b1, 1'b0, 5'd2, 32'hDEAD, 2'd1);
    send(32'h200, STD, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234, 2'd3);
    send(32'h300, RES, 1'b0, 1'b1, 1'b1, 5'd3, 32'hBEEF, 2'd0);
    send(32'h500, RES, 1'b1);
    send(32'h502, STD, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55, 2'd2);
    send(32'h600, ERET, 1'b0);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL traps_drain: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) send(32'h1000 + 4 * i, STD, 1'b0);
    send(32'h1014, TB, 1'b0);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL saturation_drain: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_block();
    send(32'h20, STD, 1'b0);
    send(32'h24, STD, 1'b0);
    rst_i = 1'b1;
    uop_valid_i = 1'b1; uop_pc_i = 32'h28; uop_itype_i = UIJ; uop_compressed_i = 1'b0;
    @(posedge clk_i); #1;
    vectors++;
    if ({blk_valid_o, blk_iaddr_o, blk_iretire_o, blk_itype_o} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: valid=%0d iaddr=%h iretire=%0d, required 0",
               blk_valid_o, blk_iaddr_o, blk_iretire_o);
    end
    rst_i = 1'b0;
    uop_valid_i = 1'b0;
    model_reset();
    send(32'h40, TB, 1'b0);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_drain: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send(32'h2000 + 2 * i, TB, 1'b1);
    send(32'h3000, STD, 1'b0);
    send(32'h3004, NTB, 1'b1);
    send(32'h3100, STD, 1'b1);
    send(32'h3102, UIJ, 1'b0);
    wait_drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_drain: %0d records outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_i = 1'b1; blk_ready_i = 1'b1;
    uop_valid_i = 1'b0; uop_pc_i = '0; uop_itype_i = '0; uop_compressed_i = 1'b0;
    uop_exception_i = 1'b0; uop_interrupt_i = 1'b0; uop_cause_i = '0; uop_tval_i = '0;
    uop_priv_i = '0;
    model_reset();
    test_reset();
    test_basic_block();
    test_backpressure();
    test_traps();
    test_saturation();
    test_reset_mid_block();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
